score_keeper: RTL and testbench
===============================

SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 SHALL have port clock, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: level; starts a new game from IDLE or DONE.
REQ-004 SHALL have port changeScore, input, 1 bit: one-cycle judgement strobe from the song/beat FSM.
REQ-005 SHALL have port addScore, input, 1 bit: judgement result, valid only with changeScore (1 = hit, 0 = miss).
REQ-006 SHALL have port songDone, input, 1 bit: level; the song has finished scrolling.
REQ-007 SHALL have port scoreBCD, output, 16 bits: four BCD digits, [15:12] thousands, [3:0] units.
REQ-008 SHALL have port streak, output, 8 bits: consecutive hits.
REQ-009 SHALL have port bestStreak, output, 8 bits: highest streak this game.
REQ-010 SHALL have port multiplier, output, 3 bits: current points-per-hit, range 1..4.
REQ-011 SHALL have port hitCount, output, 8 bits: total hits this game.
REQ-012 SHALL have port playing, output, 1 bit: high in PLAYING.
REQ-013 SHALL have port gameOver, output, 1 bit: high in DONE.
REQ-014 SHALL have port scoreUpdated, output, 1 bit: one-cycle pulse, asserted the cycle after any accepted judgement.

Function
REQ-015 SHALL implement the states IDLE, PLAYING and DONE.
REQ-016 SHALL move IDLE->PLAYING and DONE->PLAYING on start=1, clearing scoreBCD, streak, bestStreak and hitCount and setting multiplier to 1 on the same edge.
REQ-017 SHALL ignore start while in PLAYING.
REQ-018 SHALL move PLAYING->DONE on songDone=1.
REQ-019 SHALL, in DONE, hold all score outputs until start.
REQ-020 SHALL accept judgements only in PLAYING, including the cycle songDone rises; changeScore in IDLE or DONE is ignored and produces no scoreUpdated.
REQ-021 SHALL apply a hit as follows: scoreBCD += multiplier, using the registered multiplier value before this hit.
REQ-022 SHALL, on a hit, set streak = min(streak+1, 255), hitCount = min(hitCount+1, 255), and bestStreak = max(bestStreak, new streak).
REQ-023 SHALL, on a hit, set multiplier = min(1 + new_streak/8, 4); the 8th consecutive hit scores x1 and the 9th scores x2.
REQ-024 SHALL, on a miss, clear streak to 0, set multiplier to 1, and leave scoreBCD, bestStreak and hitCount unchanged.
REQ-025 SHALL update all outputs exactly one clock after the sampled changeScore, with latency 1 and back-to-back strobes accepted every cycle.
REQ-026 SHALL perform score addition in BCD with ripple carry across digits, and saturate at 9999 (e.g. 9997+4 -> 9999, never wrap).
REQ-027 SHALL decode each control input once per edge with no internal pending queue, since judgements cannot collide.

Reset
REQ-028 SHALL, on reset=0, asynchronously force IDLE, scoreBCD=0000, streak=0, bestStreak=0, hitCount=0, multiplier=1, playing=0, gameOver=0, scoreUpdated=0.
REQ-029 SHALL, after reset deasserts mid-game, remain in IDLE until start; a judgement pending at reset is discarded.

Structure
REQ-030 SHALL take the state encoding, MAX_SCORE (9999), STREAK_STEP (8), MAX_MULT (4) and STREAK_MAX (255) from the shared package theremin_pkg.
REQ-031 SHALL contain exactly one sub-module, bcd_add4: a combinational 4-digit BCD adder with 3-bit addend and saturation flag; all registers live in score_keeper.

Verification
REQ-032 SHALL be verified by this scenario: reset, start, 10 consecutive hits -> scoreBCD=0x0012, streak=10, multiplier=2, hitCount=10, 10 scoreUpdated pulses.
REQ-033 SHALL be verified by this scenario: continuing from REQ-032, one miss -> score 0x0012, streak=0, multiplier=1, bestStreak=10.
REQ-034 SHALL be verified by this scenario: from start, 37 consecutive hits -> scoreBCD=0x0100 (BCD carry across two digits), multiplier=4.
REQ-035 SHALL be verified by this scenario: sustained hits past 9999 -> scoreBCD holds 0x9999; streak saturates at 255 without wrapping.
REQ-036 SHALL be verified by this scenario: changeScore with songDone in the same cycle -> judgement applied and state becomes DONE; further strobes are ignored; start then clears outputs and state becomes PLAYING.
REQ-037 SHALL be verified by this scenario: reset pulsed low mid-game between clock edges -> outputs clear immediately, state becomes IDLE, and a strobe arriving before start is ignored.

Source files
------------

// File: rtl/theremin_pkg.sv
// Shared game constants, state encoding and the streak-to-multiplier rule
// used by the scoring datapath.
package theremin_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAYING = 2'd1,
    ST_DONE    = 2'd2
  } game_state_t;

  localparam int          MAX_SCORE     = 9999;
  localparam logic [15:0] MAX_SCORE_BCD = 16'h9999;
  localparam int          STREAK_STEP   = 8;
  localparam int          MAX_MULT      = 4;
  localparam int          STREAK_MAX    = 255;

  // One extra point per hit for every full STREAK_STEP of streak, capped.
  function automatic logic [2:0] mult_for_streak(input logic [7:0] s);
    int q;
    q = int'(s) / STREAK_STEP;
    if (q + 1 > MAX_MULT) return 3'(MAX_MULT);
    return 3'(q + 1);
  endfunction

endpackage

// File: rtl/score_keeper_if.sv
// Judgement inputs and scoreboard outputs of the score keeper.
interface score_keeper_if;
  logic        start;
  logic        changeScore;
  logic        addScore;
  logic        songDone;
  logic [15:0] scoreBCD;
  logic [7:0]  streak;
  logic [7:0]  bestStreak;
  logic [2:0]  multiplier;
  logic [7:0]  hitCount;
  logic        playing;
  logic        gameOver;
  logic        scoreUpdated;

  modport master (
    output start, changeScore, addScore, songDone,
    input  scoreBCD, streak, bestStreak, multiplier, hitCount,
           playing, gameOver, scoreUpdated
  );

  modport slave (
    input  start, changeScore, addScore, songDone,
    output scoreBCD, streak, bestStreak, multiplier, hitCount,
           playing, gameOver, scoreUpdated
  );
endinterface

// File: rtl/score_keeper_bcd_add4.sv
// Combinational 4-digit BCD adder with a small binary addend; o_sat flags
// a carry out of the thousands digit.
module bcd_add4 (
  input  logic [15:0] i_a,
  input  logic [2:0]  i_addend,
  output logic [15:0] o_sum,
  output logic        o_sat
);

  logic [4:0] w_digit;
  logic       w_carry;

  always_comb begin
    w_digit = '0;
    w_carry = 1'b0;
    o_sum   = '0;
    for (int i = 0; i < 4; i++) begin
      // Only the units digit sees the addend; higher digits see the ripple carry.
      w_digit = {1'b0, i_a[4*i +: 4]} +
                ((i == 0) ? {2'b00, i_addend} : {4'b0000, w_carry});
      if (w_digit > 5'd9) begin
        o_sum[4*i +: 4] = 4'(w_digit - 5'd10);
        w_carry         = 1'b1;
      end else begin
        o_sum[4*i +: 4] = w_digit[3:0];
        w_carry         = 1'b0;
      end
    end
    o_sat = w_carry;
  end

endmodule

// File: rtl/score_keeper.sv
// Game score keeper: IDLE/PLAYING/DONE control plus BCD score, streak,
// best streak, hit count and multiplier, all updated one clock after a judgement.
module score_keeper
  import theremin_pkg::*;
(
  input  logic           clock,
  input  logic           reset,
  score_keeper_if.slave  bus
);

  game_state_t r_state;
  logic [15:0] r_score;
  logic [7:0]  r_streak;
  logic [7:0]  r_best;
  logic [7:0]  r_hits;
  logic [2:0]  r_mult;
  logic        r_playing;
  logic        r_gameOver;
  logic        r_updated;

  logic [15:0] w_sum;
  logic        w_sat;
  logic [7:0]  w_new_streak;
  logic [7:0]  w_new_hits;

  bcd_add4 u_add (
    .i_a      (r_score),
    .i_addend (r_mult),
    .o_sum    (w_sum),
    .o_sat    (w_sat)
  );

  assign w_new_streak = (r_streak == 8'(STREAK_MAX)) ? r_streak : r_streak + 8'd1;
  assign w_new_hits   = (r_hits   == 8'(STREAK_MAX)) ? r_hits   : r_hits   + 8'd1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_score    <= '0;
      r_streak   <= '0;
      r_best     <= '0;
      r_hits     <= '0;
      r_mult     <= 3'd1;
      r_playing  <= 1'b0;
      r_gameOver <= 1'b0;
      r_updated  <= 1'b0;
    end else begin
      r_updated <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            r_state    <= ST_PLAYING;
            r_score    <= '0;
            r_streak   <= '0;
            r_best     <= '0;
            r_hits     <= '0;
            r_mult     <= 3'd1;
            r_playing  <= 1'b1;
            r_gameOver <= 1'b0;
          end
        end
        ST_PLAYING: begin
          // A judgement landing with songDone still counts before the game ends.
          if (bus.changeScore) begin
            r_updated <= 1'b1;
            if (bus.addScore) begin
              r_score  <= w_sat ? MAX_SCORE_BCD : w_sum;
              r_streak <= w_new_streak;
              r_hits   <= w_new_hits;
              r_mult   <= mult_for_streak(w_new_streak);
              if (w_new_streak > r_best) r_best <= w_new_streak;
            end else begin
              r_streak <= '0;
              r_mult   <= 3'd1;
            end
          end
          if (bus.songDone) begin
            r_state    <= ST_DONE;
            r_playing  <= 1'b0;
            r_gameOver <= 1'b1;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_playing  <= 1'b0;
          r_gameOver <= 1'b0;
        end
      endcase
    end
  end

  assign bus.scoreBCD     = r_score;
  assign bus.streak       = r_streak;
  assign bus.bestStreak   = r_best;
  assign bus.hitCount     = r_hits;
  assign bus.multiplier   = r_mult;
  assign bus.playing      = r_playing;
  assign bus.gameOver     = r_gameOver;
  assign bus.scoreUpdated = r_updated;

endmodule

// File: tb/tb_score_keeper.sv
// Directed scenario bench for score_keeper with hand-computed expectations.
module tb_score_keeper;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   pulses   = 0;

  score_keeper_if bus ();

  score_keeper dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (bus.scoreUpdated === 1'b1) pulses++;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation time limit reached (got running, need finished)");
    $fatal(1, "timeout");
  end

  task automatic do_start();
    @(negedge clock); bus.start = 1'b1;
    @(negedge clock); bus.start = 1'b0;
  endtask

  task automatic drive_judgements(input int n, input logic hit);
    for (int k = 0; k < n; k++) begin
      @(negedge clock); bus.changeScore = 1'b1; bus.addScore = hit;
    end
    @(negedge clock); bus.changeScore = 1'b0; bus.addScore = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.changeScore = 1'b0; bus.addScore = 1'b0; bus.songDone = 1'b0;
    repeat (2) @(negedge clock);
    n_checks++;
    if (bus.scoreBCD !== 16'h0000 || bus.streak !== 8'd0 || bus.bestStreak !== 8'd0 ||
        bus.hitCount !== 8'd0 || bus.multiplier !== 3'd1)
      $display("FAIL reset_values: score=%h streak=%0d best=%0d hits=%0d mult=%0d, need 0000/0/0/0/1",
               bus.scoreBCD, bus.streak, bus.bestStreak, bus.hitCount, bus.multiplier);
    else n_pass++;
    n_checks++;
    if (bus.playing !== 1'b0 || bus.gameOver !== 1'b0 || bus.scoreUpdated !== 1'b0)
      $display("FAIL reset_flags: playing=%b gameOver=%b upd=%b, need 0/0/0",
               bus.playing, bus.gameOver, bus.scoreUpdated);
    else n_pass++;
    reset = 1'b1;
    drive_judgements(2, 1'b1);
    n_checks++;
    if (bus.scoreBCD !== 16'h0000 || bus.playing !== 1'b0 || pulses !== 0)
      $display("FAIL idle_ignores_strobe: score=%h playing=%b pulses=%0d, need 0000/0/0",
               bus.scoreBCD, bus.playing, pulses);
    else n_pass++;
  endtask

  task automatic test_ten_hits();
    int base;
    do_start();
    n_checks++;
    if (bus.playing !== 1'b1 || bus.gameOver !== 1'b0)
      $display("FAIL start_playing: playing=%b gameOver=%b, need 1/0", bus.playing, bus.gameOver);
    else n_pass++;
    base = pulses;
    drive_judgements(10, 1'b1);
    n_checks++;
    if (bus.scoreBCD !== 16'h0012 || bus.streak !== 8'd10 || bus.multiplier !== 3'd2 ||
        bus.hitCount !== 8'd10 || bus.bestStreak !== 8'd10)
      $display("FAIL ten_hits: score=%h streak=%0d mult=%0d hits=%0d best=%0d, need 0012/10/2/10/10",
               bus.scoreBCD, bus.streak, bus.multiplier, bus.hitCount, bus.bestStreak);
    else n_pass++;
    n_checks++;
    if (pulses - base !== 10)
      $display("FAIL ten_hits_pulses: got %0d, need 10", pulses - base);
    else n_pass++;
  endtask

  task automatic test_miss();
    int base;
    base = pulses;
    drive_judgements(1, 1'b0);
    n_checks++;
    if (bus.scoreBCD !== 16'h0012 || bus.streak !== 8'd0 || bus.multiplier !== 3'd1 ||
        bus.bestStreak !== 8'd10 || bus.hitCount !== 8'd10 || pulses - base !== 1)
      $display("FAIL miss: score=%h streak=%0d mult=%0d best=%0d hits=%0d pulses=%0d, need 0012/0/1/10/10/1",
               bus.scoreBCD, bus.streak, bus.multiplier, bus.bestStreak, bus.hitCount, pulses - base);
    else n_pass++;
  endtask

  task automatic test_start_ignored_then_done();
    do_start();
    n_checks++;
    if (bus.scoreBCD !== 16'h0012 || bus.bestStreak !== 8'd10 || bus.playing !== 1'b1)
      $display("FAIL start_in_playing: score=%h best=%0d playing=%b, need 0012/10/1",
               bus.scoreBCD, bus.bestStreak, bus.playing);
    else n_pass++;
    @(negedge clock); bus.songDone = 1'b1;
    @(negedge clock); bus.songDone = 1'b0;
    n_checks++;
    if (bus.gameOver !== 1'b1 || bus.playing !== 1'b0 || bus.scoreBCD !== 16'h0012)
      $display("FAIL song_done: gameOver=%b playing=%b score=%h, need 1/0/0012",
               bus.gameOver, bus.playing, bus.scoreBCD);
    else n_pass++;
  endtask

  task automatic test_carry_37();
    do_start();
    n_checks++;
    if (bus.scoreBCD !== 16'h0000 || bus.bestStreak !== 8'd0 || bus.hitCount !== 8'd0 ||
        bus.playing !== 1'b1 || bus.gameOver !== 1'b0)
      $display("FAIL restart_from_done: score=%h best=%0d hits=%0d playing=%b gameOver=%b, need 0000/0/0/1/0",
               bus.scoreBCD, bus.bestStreak, bus.hitCount, bus.playing, bus.gameOver);
    else n_pass++;
    drive_judgements(37, 1'b1);
    n_checks++;
    if (bus.scoreBCD !== 16'h0100 || bus.multiplier !== 3'd4 || bus.streak !== 8'd37 ||
        bus.hitCount !== 8'd37)
      $display("FAIL carry_37: score=%h mult=%0d streak=%0d hits=%0d, need 0100/4/37/37",
               bus.scoreBCD, bus.multiplier, bus.streak, bus.hitCount);
    else n_pass++;
  endtask

  task automatic test_saturation();
    // From 100 at x4: 2474 more hits reach 9996, the next would be 10000.
    drive_judgements(2474, 1'b1);
    n_checks++;
    if (bus.scoreBCD !== 16'h9996 || bus.streak !== 8'd255 || bus.hitCount !== 8'd255 ||
        bus.bestStreak !== 8'd255)
      $display("FAIL near_max: score=%h streak=%0d hits=%0d best=%0d, need 9996/255/255/255",
               bus.scoreBCD, bus.streak, bus.hitCount, bus.bestStreak);
    else n_pass++;
    drive_judgements(1, 1'b1);
    n_checks++;
    if (bus.scoreBCD !== 16'h9999)
      $display("FAIL saturate_first: score=%h, need 9999", bus.scoreBCD);
    else n_pass++;
    drive_judgements(3, 1'b1);
    n_checks++;
    if (bus.scoreBCD !== 16'h9999 || bus.streak !== 8'd255 || bus.multiplier !== 3'd4)
      $display("FAIL saturate_hold: score=%h streak=%0d mult=%0d, need 9999/255/4",
               bus.scoreBCD, bus.streak, bus.multiplier);
    else n_pass++;
  endtask

  task automatic test_judgement_with_song_done();
    int base;
    base = pulses;
    @(negedge clock); bus.changeScore = 1'b1; bus.addScore = 1'b0; bus.songDone = 1'b1;
    @(negedge clock); bus.changeScore = 1'b0; bus.songDone = 1'b0;
    @(negedge clock);
    n_checks++;
    if (bus.streak !== 8'd0 || bus.multiplier !== 3'd1 || bus.gameOver !== 1'b1 ||
        bus.playing !== 1'b0 || pulses - base !== 1)
      $display("FAIL judge_with_done: streak=%0d mult=%0d gameOver=%b playing=%b pulses=%0d, need 0/1/1/0/1",
               bus.streak, bus.multiplier, bus.gameOver, bus.playing, pulses - base);
    else n_pass++;
    base = pulses;
    drive_judgements(3, 1'b1);
    n_checks++;
    if (bus.streak !== 8'd0 || bus.scoreBCD !== 16'h9999 || bus.hitCount !== 8'd255 ||
        bus.bestStreak !== 8'd255 || pulses - base !== 0)
      $display("FAIL done_ignores: streak=%0d score=%h hits=%0d best=%0d pulses=%0d, need 0/9999/255/255/0",
               bus.streak, bus.scoreBCD, bus.hitCount, bus.bestStreak, pulses - base);
    else n_pass++;
    do_start();
    n_checks++;
    if (bus.scoreBCD !== 16'h0000 || bus.streak !== 8'd0 || bus.bestStreak !== 8'd0 ||
        bus.hitCount !== 8'd0 || bus.multiplier !== 3'd1 || bus.playing !== 1'b1)
      $display("FAIL restart_clears: score=%h streak=%0d best=%0d hits=%0d mult=%0d playing=%b, need 0000/0/0/0/1/1",
               bus.scoreBCD, bus.streak, bus.bestStreak, bus.hitCount, bus.multiplier, bus.playing);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    int base;
    drive_judgements(3, 1'b1);
    n_checks++;
    if (bus.scoreBCD !== 16'h0003 || bus.streak !== 8'd3)
      $display("FAIL pre_reset_hits: score=%h streak=%0d, need 0003/3", bus.scoreBCD, bus.streak);
    else n_pass++;
    @(negedge clock); bus.changeScore = 1'b1; bus.addScore = 1'b1;
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (bus.scoreBCD !== 16'h0000 || bus.streak !== 8'd0 || bus.bestStreak !== 8'd0 ||
        bus.hitCount !== 8'd0 || bus.multiplier !== 3'd1 || bus.playing !== 1'b0 ||
        bus.gameOver !== 1'b0)
      $display("FAIL async_clear: score=%h streak=%0d best=%0d hits=%0d mult=%0d playing=%b gameOver=%b, need 0000/0/0/0/1/0/0",
               bus.scoreBCD, bus.streak, bus.bestStreak, bus.hitCount, bus.multiplier,
               bus.playing, bus.gameOver);
    else n_pass++;
    @(negedge clock); reset = 1'b1;
    base = pulses;
    drive_judgements(2, 1'b1);
    n_checks++;
    if (bus.scoreBCD !== 16'h0000 || bus.streak !== 8'd0 || bus.playing !== 1'b0 ||
        pulses - base !== 0)
      $display("FAIL post_reset_idle: score=%h streak=%0d playing=%b pulses=%0d, need 0000/0/0/0",
               bus.scoreBCD, bus.streak, bus.playing, pulses - base);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_ten_hits();
    test_miss();
    test_start_ignored_then_done();
    test_carry_37();
    test_saturation();
    test_judgement_with_song_done();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
